// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// Module : hazard_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  // Sequencer states. RUN is the normal flowing state.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } hz_state_e;

  // Writes to $zero are discarded, so it can never be a hazard source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default mul/div latency (cycles from start to result).
  localparam int DEFAULT_MULDIV_LAT = 4;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// Module : load_use_detect
// Brief  : Combinational load-use hazard detector between ID and EX.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst_reg,
  output logic       lu
);

  // A load in EX whose (non-zero) destination is read by the ID instruction.
  always_comb begin
    lu = ex_mem_read && (ex_dst_reg != REG_ZERO) &&
         ((ex_dst_reg == id_rs) || (id_uses_rt && (ex_dst_reg == id_rt)));
  end

endmodule : load_use_detect

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// Module : pipeline_hazard_controller
// Brief  : Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
//          MEM-resolved branch flushes and multi-cycle mul/div front-end hold,
//          plus a saturating count of stalled cycles.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_muldiv,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst_reg,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             muldiv_start,
  output logic             muldiv_abort,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cnt
);

  // Start value of the wait counter: the start cycle itself is one of the
  // MULDIV_LAT stalled cycles, and the md_cnt==0 cycle is the release cycle.
  localparam logic [7:0] MD_LOAD = 8'(MULDIV_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_dst_reg  (ex_dst_reg),
    .lu          (lu)
  );

  // Next-state and Mealy output decode; branch flush overrides everything
  // and can only force the stall enables high.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    muldiv_start = 1'b0;
    muldiv_abort = 1'b0;
    muldiv_done  = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;

    if (!rst) begin
      if (mem_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        muldiv_abort = (state_q == MD_WAIT);
        state_d      = RUN;
        md_cnt_d     = 8'd0;
      end else begin
        case (state_q)
          RUN: begin
            if (lu) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
              state_d     = LU_STALL;
            end else if (id_muldiv) begin
              muldiv_start = 1'b1;
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_flush  = 1'b1;
              md_cnt_d     = MD_LOAD;
              state_d      = MD_WAIT;
            end
          end
          LU_STALL: begin
            state_d = RUN;
          end
          MD_WAIT: begin
            if (md_cnt_q != 8'd0) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
              md_cnt_d    = md_cnt_q - 8'd1;
            end else begin
              muldiv_done = 1'b1;
              state_d     = RUN;
            end
          end
          default: begin
            state_d  = RUN;
            md_cnt_d = 8'd0;
          end
        endcase
      end
    end
  end

  // Saturating stall counter: counts cycles with the PC held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, wait counter and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule : pipeline_hazard_controller

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use hazards between ID and EX. Applies branch-taken flushes resolved in MEM. Holds the front end while a multi-cycle mul/div operation executes. Drives the write enables of PC_Reg and IF_ID_Register and the flush (bubble) inputs of the IF/ID, ID/EX and EX/MEM registers.

Parameters:
MULDIV_LAT, 4, cycles the mul/div unit needs from start to result (legal range 2..255)
CNT_W, 16, width of the saturating stall performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs  in  5  Rs field of the instruction in ID
id_rt  in  5  Rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads Rt as a source
id_muldiv  in  1  instruction in ID is a mul/div
ex_mem_read  in  1  ID/EX MemRead (a load is in EX)
ex_dst_reg  in  5  destination register of the instruction in EX
mem_branch_taken  in  1  PC_Src from the MEM stage
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID register load enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  insert a bubble into ID/EX
ex_mem_flush  out  1  clear EX/MEM to NOP
muldiv_start  out  1  one-cycle start pulse to the mul/div unit
muldiv_abort  out  1  one-cycle cancel pulse to the mul/div unit
muldiv_done  out  1  result valid; the mul/div instruction advances this cycle
stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- States: RUN, LU_STALL, MD_WAIT. Down-counter md_cnt is 8 bits wide.
- Outputs are Mealy outputs, decoded from the state and the current inputs.
- Default outputs: pc_write=1, if_id_write=1, all flushes=0, all pulses=0.
- Reset (async, any time, including mid MD_WAIT):
  - state=RUN, md_cnt=0, stall_cnt=0.
  - While rst=1, outputs hold the default values.
  - The mul/div unit shares rst; no abort pulse is issued on reset.
- Load-use hazard term (lu):
  - ex_mem_read && ex_dst_reg!=0 && (ex_dst_reg==id_rs || (id_uses_rt && ex_dst_reg==id_rt)).
  - Register 0 never causes a hazard.
- Priority, highest first: mem_branch_taken, then lu, then id_muldiv.
- mem_branch_taken=1, any state:
  - if_id_flush=id_ex_flush=ex_mem_flush=1; pc_write=1, if_id_write=1.
  - If state=MD_WAIT: muldiv_abort=1.
  - Next state RUN, md_cnt=0.
- RUN, lu=1:
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next state LU_STALL.
- LU_STALL:
  - Default outputs; the bubble in EX has removed the hazard.
  - Next state RUN.
  - A pending id_muldiv is evaluated in the following RUN cycle.
- RUN, lu=0, id_muldiv=1:
  - muldiv_start=1, pc_write=0, if_id_write=0, id_ex_flush=1.
  - md_cnt<=MULDIV_LAT-1; next state MD_WAIT.
- MD_WAIT, md_cnt!=0:
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - md_cnt decrements by 1 per cycle.
- MD_WAIT, md_cnt==0:
  - muldiv_done=1 with default enables, so the instruction moves to EX.
  - Next state RUN.
- Total front-end stall for a mul/div = MULDIV_LAT cycles.
- stall_cnt increments on every clock edge where pc_write=0 and rst=0. It saturates at 2^CNT_W-1 and never wraps.
- Branch flush cycles are not stalls and are not counted.
- No combinational path from mem_branch_taken to the stall enables other than forcing them to 1.

Decomposition:
- Shared package hazard_pkg: state enum (RUN, LU_STALL, MD_WAIT), REG_ZERO constant (5'd0), default MULDIV_LAT.
- One combinational sub-module, load_use_detect: computes lu from id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst_reg.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst_reg=8, id_rs=8 in RUN:
  - One cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then LU_STALL with defaults, then RUN.
  - stall_cnt=1.
- Register zero: ex_mem_read=1, ex_dst_reg=0, id_rs=0 -> no stall; stall_cnt stays 0. Also id_uses_rt=0 with id_rt matching -> no stall.
- Mul/div with MULDIV_LAT=4:
  - id_muldiv=1 -> muldiv_start pulse, then 3 stall cycles, then muldiv_done=1 on cycle 4.
  - pc_write low for exactly 4 cycles; stall_cnt=4.
- Branch during MD_WAIT (md_cnt=2): mem_branch_taken=1 -> all three flushes=1, muldiv_abort=1, pc_write=1; next state RUN, no muldiv_done.
- Simultaneous events:
  - lu=1 and id_muldiv=1 -> load-use stall first (1 cycle), muldiv_start in the cycle after LU_STALL.
  - mem_branch_taken with lu=1 -> flush wins, no stall.
- Async reset during MD_WAIT: assert rst mid-cycle -> outputs return to defaults immediately; state RUN, stall_cnt=0 after release. With CNT_W=4, forcing 20 stall cycles -> stall_cnt=15.
